frame_buffer_writer: RTL and testbench

//  Write side of the sprite/camera frame buffer. The read side maps screen coords to

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_addr_gen.sv | 57 +++++
 rtl/frame_buffer_writer.sv | 101 ++++++++++
 tb/tb_frame_buffer_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and encodings, imported by both the writer and the scaler
// so that the two ends of the BRAM agree on image size and scale codes.
package fb_pkg;
  localparam int FB_IMG_W  = 240;
  localparam int FB_IMG_H  = 320;
  localparam int FB_PIX_W  = 16;
  localparam int FB_ADDR_W = 17;
  localparam int HCNT_W    = 11;
  localparam int VCNT_W    = 10;

  typedef enum logic [1:0] {FB_IDLE, FB_ARMED, FB_CAPTURE, FB_DONE} fb_state_t;
  typedef enum logic [1:0] {SCALE_1X, SCALE_2X, SCALE_4X} scale_t;

  // The unused encoding 2'b11 decimates like 4x.
  function automatic logic [1:0] scale_to_shift(input logic [1:0] scale);
    case (scale)
      SCALE_1X: return 2'd0;
      SCALE_2X: return 2'd1;
      default:  return 2'd2;
    endcase
  endfunction
endpackage

// File: rtl/fb_addr_gen.sv
// Decimation filter and row-major address generator: masks/bounds-checks the source
// coordinates, forms row*IMG_W+col and registers the resulting BRAM write.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int IMG_W  = FB_IMG_W,
  parameter int IMG_H  = FB_IMG_H,
  parameter int PIX_W  = FB_PIX_W,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        shift,
  input  logic [HCNT_W-1:0] hcount,
  input  logic [VCNT_W-1:0] vcount,
  input  logic [PIX_W-1:0]  pixel,
  output logic              last,
  output logic              we_p1,
  output logic [ADDR_W-1:0] waddr_p1,
  output logic [PIX_W-1:0]  wdata_p1
);
  logic [HCNT_W-1:0] hmask, col;
  logic [VCNT_W-1:0] vmask, row;
  logic [31:0]       addr_full;
  logic              accept;

  always_comb begin
    hmask     = HCNT_W'((32'd1 << shift) - 32'd1);
    vmask     = VCNT_W'((32'd1 << shift) - 32'd1);
    col       = hcount >> shift;
    row       = vcount >> shift;
    addr_full = 32'(row) * 32'(IMG_W) + 32'(col);
    // Out-of-range coordinates are dropped here, so the address can never wrap.
    accept    = en
             && ((hcount & hmask) == '0)
             && ((vcount & vmask) == '0)
             && (32'(col) < 32'(IMG_W))
             && (32'(row) < 32'(IMG_H));
    last      = accept && (addr_full == 32'(IMG_W * IMG_H - 1));
  end

  // ---- stage p1: registered BRAM write ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      we_p1 <= accept;
      if (accept) begin
        waddr_p1 <= addr_full[ADDR_W-1:0];
        wdata_p1 <= pixel;
      end
    end
  end
endmodule

// File: rtl/frame_buffer_writer.sv
// Snapshot writer: arms on capture_req_in, captures one decimated frame from the pixel
// stream into BRAM port A, then pulses frame_done_out.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int IMG_W  = FB_IMG_W,
  parameter int IMG_H  = FB_IMG_H,
  parameter int PIX_W  = FB_PIX_W,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              capture_req_in,
  input  logic [1:0]        scale_in,
  input  logic              pixel_valid_in,
  input  logic              sof_in,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic [VCNT_W-1:0] vcount_in,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic              we_out,
  output logic [ADDR_W-1:0] waddr_out,
  output logic [PIX_W-1:0]  wdata_out,
  output logic              busy_out,
  output logic              frame_done_out
);
  logic [1:0] rst_sync;
  logic       rst_int;
  fb_state_t  state, state_nxt;
  logic [1:0] shift_q, shift_cur;
  logic       gen_en, last;

  // Reset asserts asynchronously but releases two edges after rst_in falls.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) rst_sync <= 2'b11;
    else        rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  always_ff @(posedge clk_in or posedge rst_int) begin
    if (rst_int) begin
      state   <= FB_IDLE;
      shift_q <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == FB_ARMED && pixel_valid_in && sof_in)
        shift_q <= scale_to_shift(scale_in);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FB_IDLE:    if (capture_req_in) state_nxt = FB_ARMED;
      FB_ARMED:   if (pixel_valid_in && sof_in) state_nxt = FB_CAPTURE;
      FB_CAPTURE: if (pixel_valid_in && (sof_in || last)) state_nxt = FB_DONE;
      FB_DONE:    state_nxt = FB_IDLE;
      default:    state_nxt = FB_IDLE;
    endcase
  end

  // The sof pixel is written while still ARMED, so it uses scale_in directly;
  // a later sof during CAPTURE ends the frame and is not written.
  always_comb begin
    gen_en         = 1'b0;
    shift_cur      = shift_q;
    busy_out       = 1'b0;
    frame_done_out = 1'b0;
    case (state)
      FB_ARMED: begin
        busy_out  = 1'b1;
        shift_cur = scale_to_shift(scale_in);
        gen_en    = pixel_valid_in && sof_in;
      end
      FB_CAPTURE: begin
        busy_out = 1'b1;
        gen_en   = pixel_valid_in && !sof_in;
      end
      FB_DONE: frame_done_out = 1'b1;
      default: ;
    endcase
  end

  fb_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk_in),
    .rst      (rst_int),
    .en       (gen_en),
    .shift    (shift_cur),
    .hcount   (hcount_in),
    .vcount   (vcount_in),
    .pixel    (pixel_in),
    .last     (last),
    .we_p1    (we_out),
    .waddr_p1 (waddr_out),
    .wdata_p1 (wdata_out)
  );
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer with a scoreboard of expected BRAM writes.
// Image height is reduced so full-frame captures stay short; width keeps its default.
module tb_frame_buffer_writer;
  localparam int W  = 240;
  localparam int H  = 104;
  localparam int PW = 16;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    scale = 2'd0;
  logic          valid = 1'b0;
  logic          sof = 1'b0;
  logic [10:0]   hc = '0;
  logic [9:0]    vc = '0;
  logic [PW-1:0] pix = '0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wdata;
  logic          busy;
  logic          done;

  typedef struct {int addr; int data; int due;} exp_t;
  exp_t q[$];
  exp_t e;

  int cyc = 0, checks = 0, errors = 0;
  int wr_cnt = 0, done_cnt = 0, exp_done = 0;
  int last_addr = -1, data_241 = -1, data_242 = -1;
  int m_st = 0, m_sh = 0;
  int wr0, dn0;

  frame_buffer_writer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .capture_req_in (req),
    .scale_in       (scale),
    .pixel_valid_in (valid),
    .sof_in         (sof),
    .hcount_in      (hc),
    .vcount_in      (vc),
    .pixel_in       (pix),
    .we_out         (we),
    .waddr_out      (waddr),
    .wdata_out      (wdata),
    .busy_out       (busy),
    .frame_done_out (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: every write must match the oldest expectation, one cycle after its pixel.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (we === 1'b1) begin
      wr_cnt++;
      if (q.size() == 0) begin
        check("spurious_write_addr", 32'(waddr), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("waddr", 32'(waddr), e.addr);
        check("wdata", 32'(wdata), e.data);
        check("write_cycle", cyc, e.due);
      end
      last_addr = int'(waddr);
      if (waddr == AW'(241)) data_241 = int'(wdata);
      if (waddr == AW'(242)) data_242 = int'(wdata);
    end
  end

  function automatic bit model_acc(input int h, input int v, input int sh, output int a);
    int f;
    f = 1 << sh;
    a = (v / f) * W + (h / f);
    return (h % f == 0) && (v % f == 0) && (h / f < W) && (v / f < H);
  endfunction

  function automatic int pd(input int h, input int v);
    return ((h & 255) << 8) | (v & 255);
  endfunction

  // Drive one cycle of stimulus and advance the reference model alongside it.
  task automatic step(input bit vl, input bit sf, input int h, input int v, input int d);
    int a;
    valid = vl; sof = sf; hc = 11'(h); vc = 10'(v); pix = PW'(d);
    case (m_st)
      0: if (req) m_st = 1;
      1: if (vl && sf) begin
           m_sh = (scale == 2'd0) ? 0 : (scale == 2'd1) ? 1 : 2;
           if (model_acc(h, v, m_sh, a)) q.push_back('{addr: a, data: d & 16'hFFFF, due: cyc + 1});
           m_st = 2;
         end
      2: if (vl) begin
           if (sf) begin
             m_st = 3; exp_done++;
           end else if (model_acc(h, v, m_sh, a)) begin
             q.push_back('{addr: a, data: d & 16'hFFFF, due: cyc + 1});
             if (a == W * H - 1) begin m_st = 3; exp_done++; end
           end
         end
      default: m_st = 0;
    endcase
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    // Reset values, checked before any clock edge.
    rst = 1'b1;
    #1;
    check("rst_we", 32'(we), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    check("idle_busy", 32'(busy), 0);

    // 1x full-frame capture.
    wr0 = wr_cnt; dn0 = done_cnt;
    scale = 2'd0; req = 1'b1;
    step(1'b0, 1'b0, 0, 0, 0);
    check("t1_armed_busy", 32'(busy), 1);
    for (int v = 0; v < H; v++)
      for (int h = 0; h < W; h++)
        step(1'b1, (h == 0 && v == 0), h, v, int'($urandom_range(0, 65535)));
    check("t1_done_after_last", 32'(done), 1);
    idle(3);
    check("t1_writes", wr_cnt - wr0, W * H);
    check("t1_last_addr", last_addr, W * H - 1);
    check("t1_done_cnt", done_cnt - dn0, 1);
    check("t1_model_done", done_cnt, exp_done);
    check("t1_queue_empty", q.size(), 0);
    check("t1_busy", 32'(busy), 0);

    // 2x decimation of a double-size frame; scale_in changes mid-frame.
    wr0 = wr_cnt; dn0 = done_cnt;
    scale = 2'd1; req = 1'b1;
    idle(1);
    for (int v = 0; v < 2 * H; v++) begin
      if (v == 4) scale = 2'd0;
      if (v < 4) begin
        for (int h = 0; h < 2 * W; h++) step(1'b1, (h == 0 && v == 0), h, v, pd(h, v));
      end else if (v % 2 == 0) begin
        for (int h = 0; h < 2 * W; h += 2) step(1'b1, 1'b0, h, v, pd(h, v));
      end else begin
        step(1'b1, 1'b0, 0, v, pd(0, v));
        step(1'b1, 1'b0, 1, v, pd(1, v));
      end
    end
    idle(3);
    check("t2_writes", wr_cnt - wr0, W * H);
    check("t2_addr241_from_2_2", data_241, 32'h0202);
    check("t2_done_cnt", done_cnt - dn0, 1);
    check("t2_queue_empty", q.size(), 0);

    // 4x decimation: sparse coordinates, drops at and beyond the right edge.
    wr0 = wr_cnt; dn0 = done_cnt;
    scale = 2'd2; req = 1'b1;
    idle(1);
    step(1'b1, 1'b1, 0, 0, pd(0, 0));
    step(1'b1, 1'b0, 8, 4, pd(8, 4));
    step(1'b1, 1'b0, 9, 4, pd(9, 4));
    step(1'b1, 1'b0, 1000, 0, pd(1000, 0));
    step(1'b1, 1'b0, 960, 0, pd(960, 0));
    step(1'b1, 1'b0, 956, 0, pd(956, 0));
    step(1'b0, 1'b1, 4, 4, 16'h5555);
    check("t3_invalid_sof_held", 32'(busy), 1);
    scale = 2'd0;
    step(1'b1, 1'b0, 4, 4, pd(4, 4));
    step(1'b1, 1'b1, 0, 0, 16'hDEAD);
    idle(3);
    check("t3_addr242_from_8_4", data_242, 32'h0804);
    check("t3_addr241_from_4_4", data_241, 32'h0404);
    check("t3_writes", wr_cnt - wr0, 4);
    check("t3_done_cnt", done_cnt - dn0, 1);
    check("t3_queue_empty", q.size(), 0);

    // Short source frame ended by an early sof; capture_req ignored in CAPTURE and DONE.
    wr0 = wr_cnt; dn0 = done_cnt;
    scale = 2'd0; req = 1'b1;
    idle(1);
    for (int v = 0; v < 99; v++) begin
      if (v == 50) req = 1'b1;
      step(1'b1, (v == 0), 0, v, pd(0, v));
      step(1'b1, 1'b0, W - 1, v, pd(W - 1, v));
    end
    for (int h = 0; h < W; h++) step(1'b1, 1'b0, h, 99, pd(h, 99));
    step(1'b1, 1'b1, 0, 100, 16'hBEEF);
    check("t4_done_pulse", 32'(done), 1);
    req = 1'b1;
    step(1'b0, 1'b0, 0, 0, 0);
    idle(3);
    check("t4_last_addr", last_addr, 23999);
    check("t4_writes", wr_cnt - wr0, 99 * 2 + W);
    check("t5_single_done", done_cnt - dn0, 1);
    check("t5_busy_after_done", 32'(busy), 0);
    step(1'b1, 1'b1, 0, 0, 16'h1234);
    step(1'b1, 1'b0, 1, 0, 16'h1235);
    idle(2);
    check("t5_req_not_queued", wr_cnt - wr0, 99 * 2 + W);
    check("t5_queue_empty", q.size(), 0);

    // Asynchronous reset between edges in the middle of a capture.
    scale = 2'd0; req = 1'b1;
    idle(1);
    step(1'b1, 1'b1, 0, 0, 16'h0001);
    step(1'b1, 1'b0, 1, 0, 16'h0002);
    step(1'b1, 1'b0, 2, 0, 16'h0003);
    check("t6_we_before_rst", 32'(we), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_we", 32'(we), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_done", 32'(done), 0);
    q.delete();
    m_st = 0;
    wr0 = wr_cnt; dn0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    step(1'b1, 1'b1, 0, 0, 16'h00AA);
    step(1'b1, 1'b0, 1, 0, 16'h00AB);
    idle(2);
    check("t6_no_writes_after_rst", wr_cnt - wr0, 0);
    check("t6_no_done_after_rst", done_cnt - dn0, 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
